// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST controller.
package alu_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRIVE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int          ERR_CNT_W = 16;

  localparam logic [2:0] ALOP_C0 = 3'b000;
  localparam logic [2:0] ALOP_C1 = 3'b001;
  localparam logic [2:0] ALOP_C2 = 3'b010;
  localparam logic [2:0] ALOP_C3 = 3'b011;
  localparam logic [2:0] ALOP_C4 = 3'b100;
  localparam logic [2:0] ALOP_C5 = 3'b101;
  localparam logic [2:0] ALOP_C6 = 3'b110;

  // One step of the right-shifting Galois LFSR (x^32+x^22+x^2+x+1).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/result bus between the BIST controller (master) and the ALU (slave).
interface alu_bist_if #(parameter int W = 32);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [2:0]   ALOP;
  logic [W-1:0] R0;
  logic [W-1:0] R0_verify;

  modport master (output a, b, c_in, ALOP, input R0, R0_verify);
  modport slave  (input a, b, c_in, ALOP, output R0, R0_verify);
endinterface

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois LFSR; load restarts from SEED, adv steps twice (one operand pair).
module alu_bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] state,
  output logic [31:0] state_nxt
);

  assign state_nxt = lfsr_step(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED;
    else if (load) state <= SEED;
    else if (adv)  state <= lfsr_step(state_nxt);
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU BIST: LFSR operands, full ALOP sweep, R0 vs R0_verify compare with error count.
// Define ALU_BIST_LOG_EN to capture the first failing vector into err_*.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          W          = 32,
  parameter int          N_VEC      = 16,
  parameter int          NUM_OPS    = 7,
  parameter int          RESULT_LAT = 1,
  parameter logic [31:0] SEED       = 32'h00000001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  alu_bist_if.master           alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [W-1:0]         err_a,
  output logic [W-1:0]         err_b,
  output logic [2:0]           err_op,
  output logic                 err_cin,
  output logic                 err_valid
);

  localparam logic [2:0]  OP_LAST  = 3'(NUM_OPS - 1);
  localparam logic [15:0] VEC_LAST = 16'(N_VEC - 1);
  localparam logic [3:0]  WAIT_LD  = 4'(RESULT_LAT - 1);

  state_t                 state;
  logic [2:0]             op;
  logic [15:0]            vec;
  logic [3:0]             wcnt;
  logic [31:0]            lfsr_s, lfsr_s1;
  logic                   run_start, mism;
  logic [ERR_CNT_W-1:0]   cnt_nxt;

  assign run_start = start && (state == IDLE || state == DONE);
  assign mism      = (alu.R0 != alu.R0_verify);
  assign cnt_nxt   = (mism && err_count != '1) ? err_count + 1'b1 : err_count;

  alu_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (run_start),
    .adv       (state == LOAD),
    .state     (lfsr_s),
    .state_nxt (lfsr_s1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      vec       <= '0;
      wcnt      <= '0;
      alu.a     <= '0;
      alu.b     <= '0;
      alu.c_in  <= 1'b0;
      alu.ALOP  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          err_count <= '0;
          op        <= '0;
          vec       <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          alu.a    <= lfsr_s[W-1:0];
          alu.b    <= lfsr_s1[W-1:0];
          alu.c_in <= lfsr_s[31];
          state    <= DRIVE;
        end
        DRIVE: begin
          alu.ALOP <= op;
          if (RESULT_LAT == 0) state <= CHECK;
          else begin
            wcnt  <= WAIT_LD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) state <= CHECK;
          else              wcnt  <= wcnt - 4'd1;
        end
        CHECK: begin
          err_count <= cnt_nxt;
          if (op != OP_LAST) begin
            op    <= op + 3'd1;
            state <= DRIVE;
          end else if (vec != VEC_LAST) begin
            vec   <= vec + 16'd1;
            op    <= '0;
            state <= LOAD;
          end else begin
            // pass must reflect a mismatch seen in this final CHECK too
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (cnt_nxt == '0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_BIST_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst || run_start) begin
      err_a     <= '0;
      err_b     <= '0;
      err_op    <= '0;
      err_cin   <= 1'b0;
      err_valid <= 1'b0;
    end else if (state == CHECK && mism && !err_valid) begin
      err_a     <= alu.a;
      err_b     <= alu.b;
      err_op    <= op;
      err_cin   <= alu.c_in;
      err_valid <= 1'b1;
    end
  end
`else
  assign err_a     = '0;
  assign err_b     = '0;
  assign err_op    = '0;
  assign err_cin   = 1'b0;
  assign err_valid = 1'b0;
`endif

endmodule
